// File: rtl/wbm_cmd_master.sv
// Single-transfer Wishbone classic bus master: one command in, one Wishbone cycle,
// one response out, with bus-error and timeout reporting.
module wbm_cmd_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic [1:0]          rsp_status,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]      ST_OK    = 2'b00;
    localparam logic [1:0]      ST_ERR   = 2'b01;
    localparam logic [1:0]      ST_TMO   = 2'b10;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign wbm_sel_o = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= BUS;
                    end
                end
                BUS: begin
                    // Error outranks a simultaneous ack; an ack on the last allowed
                    // cycle still completes normally.
                    if (wbm_err_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        rsp_status <= ST_ERR;
                        rsp_dat    <= '0;
                        rsp_valid  <= 1'b1;
                        r_state    <= RESP;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        rsp_status <= ST_OK;
                        rsp_dat    <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_valid  <= 1'b1;
                        r_state    <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        rsp_status <= ST_TMO;
                        rsp_dat    <= '0;
                        rsp_valid  <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Randomised self-checking bench for wbm_cmd_master against a transaction-level model
// of the expected bus duration and response.
module tb_wbm_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic        nxt_we;
    logic [31:0] nxt_adr;
    logic [31:0] nxt_dat;

    wbm_cmd_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    always #5 clk = ~clk;

    // Reference model. kind: 0 ack, 1 err, 2 ack+err, 3 silent slave.
    // The slave reacts on bus cycle number 'delay' (0-based).
    function automatic int exp_cycles(input int kind, input int delay);
        return (kind != 3 && delay < TO) ? delay + 1 : TO;
    endfunction

    function automatic logic [1:0] exp_status(input int kind, input int delay);
        if (kind == 3 || delay >= TO) return 2'b10;
        return (kind == 0) ? 2'b00 : 2'b01;
    endfunction

    function automatic logic [31:0] exp_rdat(input logic we, input int kind, input int delay,
                                             input logic [31:0] rdat);
        return (exp_status(kind, delay) == 2'b00 && !we) ? rdat : 32'h0;
    endfunction

    // Drives one command, plays the slave, observes the bus and the response.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int delay, input int kind,
                           input int bp, input bit pend, input bit stray,
                           output int cyc_n, output bit stable, output bit rv,
                           output logic [31:0] rd, output logic [1:0] rs,
                           output bit held, output bit cr_low, output bit cleared);
        int n;
        stable = 1'b1;
        held   = 1'b1;
        cr_low = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = wdat;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cyc_n = 0;
        for (int c = 0; c < TO + 4 && wbm_cyc_o; c++) begin
            cyc_n++;
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr ||
                wbm_dat_o !== wdat || wbm_sel_o !== 4'hf || rsp_valid !== 1'b0 ||
                cmd_ready !== 1'b0)
                stable = 1'b0;
            wbm_dat_i = $urandom;
            if (c == delay && kind != 3) begin
                wbm_ack_i = (kind != 1);
                wbm_err_i = (kind != 0);
                if (kind == 0) wbm_dat_i = rdat;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        rv = rsp_valid;
        rd = rsp_dat;
        rs = rsp_status;
        if (pend) begin
            cmd_valid = 1'b1;
            cmd_we    = nxt_we;
            cmd_adr   = nxt_adr;
            cmd_dat   = nxt_dat;
        end
        for (int i = 0; i < bp; i++) begin
            wbm_ack_i = stray && (i == 1);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== rd || rsp_status !== rs) held = 1'b0;
            if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) cr_low = 1'b0;
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cleared = (rsp_valid === 1'b0);
    endtask

    task automatic test_reset;
        logic [31:0] w_bad;
        reset     = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        w_bad = {31'h0, cmd_ready};
        if (w_bad !== 32'h0) begin
            $display("FAIL reset_cmd_ready got %0d want 0", cmd_ready); n_fail++;
        end
        n_tests++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat,
             rsp_status} !== '0) begin
            $display("FAIL reset_outputs cyc=%0b stb=%0b we=%0b adr=%h dat=%h rv=%0b rd=%h rs=%0d want all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat,
                     rsp_status);
            n_fail++;
        end
        n_tests++;
        cmd_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            $display("FAIL reset_release cmd_ready=%0b cyc=%0b want 1/0", cmd_ready, wbm_cyc_o);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_write;
        int cyc_n; bit st, rv, hl, cl, cr; logic [31:0] rd; logic [1:0] rs;
        run_txn(1'b1, 32'h0001_dead, 32'hdeadbeef, 32'h5555_aaaa, 0, 0, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if (cyc_n !== 1) begin $display("FAIL write_cycles got %0d want 1", cyc_n); n_fail++; end
        n_tests++;
        if (st !== 1'b1) begin $display("FAIL write_bus_signals got unstable want stable"); n_fail++; end
        n_tests++;
        if ({rv, rs, rd} !== {1'b1, 2'b00, 32'h0}) begin
            $display("FAIL write_rsp got v=%0b st=%0d dat=%h want 1/0/0", rv, rs, rd); n_fail++;
        end
        n_tests++;
        if (cl !== 1'b1) begin $display("FAIL write_rsp_clear got 0 want 1"); n_fail++; end
        n_tests++;
    endtask

    task automatic test_read;
        int cyc_n; bit st, rv, hl, cl, cr; logic [31:0] rd; logic [1:0] rs;
        run_txn(1'b0, 32'h0005_dead, $urandom, 32'h1234_5678, 3, 0, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if (cyc_n !== 4) begin $display("FAIL read_cycles got %0d want 4", cyc_n); n_fail++; end
        n_tests++;
        if (st !== 1'b1) begin $display("FAIL read_adr_stable got unstable want stable"); n_fail++; end
        n_tests++;
        if ({rv, rs, rd} !== {1'b1, 2'b00, 32'h1234_5678}) begin
            $display("FAIL read_rsp got v=%0b st=%0d dat=%h want 1/0/12345678", rv, rs, rd);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_error;
        int cyc_n; bit st, rv, hl, cl, cr; logic [31:0] rd; logic [1:0] rs;
        run_txn(1'b0, $urandom, $urandom, 32'hcafe_f00d, 1, 1, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if ({cyc_n, rs, rd} !== {32'd2, 2'b01, 32'h0}) begin
            $display("FAIL err_rsp got cyc=%0d st=%0d dat=%h want 2/1/0", cyc_n, rs, rd); n_fail++;
        end
        n_tests++;
        run_txn(1'b0, $urandom, $urandom, 32'hcafe_f00d, 0, 2, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if ({cyc_n, rs, rd} !== {32'd1, 2'b01, 32'h0}) begin
            $display("FAIL err_over_ack got cyc=%0d st=%0d dat=%h want 1/1/0", cyc_n, rs, rd);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_timeout;
        int cyc_n; bit st, rv, hl, cl, cr, bad; logic [31:0] rd; logic [1:0] rs;
        run_txn(1'b0, $urandom, $urandom, 32'h0, 0, 3, 4, 1'b0, 1'b1,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if (cyc_n !== TO) begin $display("FAIL tmo_cycles got %0d want %0d", cyc_n, TO); n_fail++; end
        n_tests++;
        if ({rv, rs, rd} !== {1'b1, 2'b10, 32'h0}) begin
            $display("FAIL tmo_rsp got v=%0b st=%0d dat=%h want 1/2/0", rv, rs, rd); n_fail++;
        end
        n_tests++;
        if ({hl, cl} !== 2'b11) begin
            $display("FAIL tmo_late_ack_in_resp got held=%0b clr=%0b want 1/1", hl, cl); n_fail++;
        end
        n_tests++;
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        if (bad !== 1'b0) begin $display("FAIL stray_ack_idle got reaction want none"); n_fail++; end
        n_tests++;
        // Ack on the last permitted cycle completes normally.
        run_txn(1'b0, $urandom, $urandom, 32'h0bad_cafe, TO - 1, 0, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if ({cyc_n, rs, rd} !== {TO, 2'b00, 32'h0bad_cafe}) begin
            $display("FAIL ack_at_limit got cyc=%0d st=%0d dat=%h want %0d/0/0badcafe",
                     cyc_n, rs, rd, TO);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_backpressure;
        int cyc_n; bit st, rv, hl, cl, cr, bad; logic [31:0] rd, rdat; logic [1:0] rs;
        nxt_we  = 1'b0;
        nxt_adr = $urandom;
        nxt_dat = $urandom;
        rdat    = $urandom;
        run_txn(1'b0, $urandom, $urandom, 32'h7777_1111, 2, 0, 5, 1'b1, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if ({hl, cr, cl} !== 3'b111) begin
            $display("FAIL bp_hold got held=%0b cmd_ready_low=%0b clr=%0b want 1/1/1", hl, cr, cl);
            n_fail++;
        end
        n_tests++;
        if (rd !== 32'h7777_1111) begin $display("FAIL bp_first_dat got %h want 77771111", rd); n_fail++; end
        n_tests++;
        run_txn(nxt_we, nxt_adr, nxt_dat, rdat, 0, 0, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if ({cyc_n, st, rs, rd} !== {32'd1, 1'b1, 2'b00, rdat}) begin
            $display("FAIL bp_second got cyc=%0d stable=%0b st=%0d dat=%h want 1/1/0/%h",
                     cyc_n, st, rs, rd, rdat);
            n_fail++;
        end
        n_tests++;
        bad = 1'b0;
        repeat (4) begin
            if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        if (bad !== 1'b0) begin $display("FAIL bp_no_duplicate got extra txn want none"); n_fail++; end
        n_tests++;
    endtask

    task automatic test_reset_mid_bus;
        int cyc_n; bit st, rv, hl, cl, cr, bad; logic [31:0] rd; logic [1:0] rs;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        if (wbm_cyc_o !== 1'b1) begin $display("FAIL rst_bus_started got 0 want 1"); n_fail++; end
        n_tests++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, wbm_adr_o} !== '0) begin
            $display("FAIL rst_mid_bus got cyc=%0b stb=%0b rv=%0b adr=%h want 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, wbm_adr_o);
            n_fail++;
        end
        n_tests++;
        bad = 1'b0;
        repeat (4) begin
            wbm_ack_i = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) bad = 1'b1;
        end
        wbm_ack_i = 1'b0;
        if (bad !== 1'b0) begin $display("FAIL rst_no_response got response want none"); n_fail++; end
        n_tests++;
        run_txn(1'b0, 32'h00ab_cdef, $urandom, 32'h600d_d00d, 1, 0, 0, 1'b0, 1'b0,
                cyc_n, st, rv, rd, rs, hl, cr, cl);
        if ({cyc_n, st, rs, rd} !== {32'd2, 1'b1, 2'b00, 32'h600d_d00d}) begin
            $display("FAIL rst_next_cmd got cyc=%0d stable=%0b st=%0d dat=%h want 2/1/0/600dd00d",
                     cyc_n, st, rs, rd);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_random;
        int cyc_n, kind, delay, bp; bit st, rv, hl, cl, cr; logic we;
        logic [31:0] rd, adr, wdat, rdat; logic [1:0] rs;
        for (int t = 0; t < 30; t++) begin
            kind  = $urandom_range(0, 3);
            delay = $urandom_range(0, TO + 2);
            bp    = $urandom_range(0, 3);
            we    = 1'($urandom_range(0, 1));
            adr   = $urandom;
            wdat  = $urandom;
            rdat  = $urandom;
            run_txn(we, adr, wdat, rdat, delay, kind, bp, 1'b0, 1'b0,
                    cyc_n, st, rv, rd, rs, hl, cr, cl);
            if (cyc_n !== exp_cycles(kind, delay) || st !== 1'b1) begin
                $display("FAIL rand%0d_bus got cyc=%0d stable=%0b want %0d/1 (kind %0d delay %0d)",
                         t, cyc_n, st, exp_cycles(kind, delay), kind, delay);
                n_fail++;
            end
            n_tests++;
            if ({rv, rs, rd} !== {1'b1, exp_status(kind, delay), exp_rdat(we, kind, delay, rdat)}) begin
                $display("FAIL rand%0d_rsp got v=%0b st=%0d dat=%h want 1/%0d/%h", t, rv, rs, rd,
                         exp_status(kind, delay), exp_rdat(we, kind, delay, rdat));
                n_fail++;
            end
            n_tests++;
            if ({hl, cl} !== 2'b11) begin
                $display("FAIL rand%0d_hold got held=%0b clr=%0b want 1/1", t, hl, cl); n_fail++;
            end
            n_tests++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
